// File: rtl/bk_multiword_add_seq_if.sv
// Operand, adder and sum signal bundle for the multiword add/sub sequencer.
// master: operand producer, shared 8-bit adder and sum consumer; slave: sequencer.
// OVF exists only when BK_SEQ_OVERFLOW_EN is defined.
interface bk_multiword_add_seq_if;
   logic       START;
   logic       SUB;
   logic       C_IN;
   logic       ABORT;
   logic       OP_VALID;
   logic [7:0] OP_A;
   logic [7:0] OP_B;
   logic       OP_READY;
   logic [7:0] ADD_A;
   logic [7:0] ADD_B;
   logic       ADD_C0;
   logic [7:0] ADD_S;
   logic       ADD_COUT;
   logic       SUM_VALID;
   logic [7:0] SUM;
   logic       SUM_LAST;
   logic       SUM_READY;
   logic       BUSY;
   logic       DONE;
   logic       C_OUT;
`ifdef BK_SEQ_OVERFLOW_EN
   logic       OVF;
`endif

   modport master (
      output START, SUB, C_IN, ABORT, OP_VALID, OP_A, OP_B, ADD_S, ADD_COUT, SUM_READY,
`ifdef BK_SEQ_OVERFLOW_EN
      input  OVF,
`endif
      input  OP_READY, ADD_A, ADD_B, ADD_C0, SUM_VALID, SUM, SUM_LAST, BUSY, DONE, C_OUT
   );

   modport slave (
      input  START, SUB, C_IN, ABORT, OP_VALID, OP_A, OP_B, ADD_S, ADD_COUT, SUM_READY,
`ifdef BK_SEQ_OVERFLOW_EN
      output OVF,
`endif
      output OP_READY, ADD_A, ADD_B, ADD_C0, SUM_VALID, SUM, SUM_LAST, BUSY, DONE, C_OUT
   );
endinterface

// File: rtl/bk_multiword_add_seq.sv
// Chains an external 8-bit adder over NUM_WORDS bytes for multi-precision add/sub (LSB first).
// Latency: each sum byte is registered 1 cycle after its operand byte is accepted; 1 byte/cycle.
// Backpressure: single output register; OP_READY drops while a sum byte is held and SUM_READY is low.
// Optional signed-overflow flag OVF is built when BK_SEQ_OVERFLOW_EN is defined.
module bk_multiword_add_seq #(
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = 8
) (
   input logic                   CLK,
   input logic                   RST_N,
   bk_multiword_add_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             mode;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       sum_q;
   logic             sum_vld_q;
   logic             sum_last_q;
   logic             c_out_q;
`ifdef BK_SEQ_OVERFLOW_EN
   logic             ovf_q;
`endif

   logic op_rdy;
   logic accept;
   logic last_word;
   logic sum_hs;
   logic start_go;
   logic done_fire;

   // Subtraction is A + ~B + 1; the +1 comes from the carry seeded at START.
   assign bus.ADD_A  = bus.OP_A;
   assign bus.ADD_B  = mode ? ~bus.OP_B : bus.OP_B;
   assign bus.ADD_C0 = carry;

   assign op_rdy    = (state == RUN) && (!sum_vld_q || bus.SUM_READY);
   assign accept    = bus.OP_VALID && op_rdy;
   assign last_word = (cnt == CNT_W'(NUM_WORDS - 1));
   assign sum_hs    = sum_vld_q && bus.SUM_READY;
   assign start_go  = (state == IDLE) && bus.START && !bus.ABORT;
   // DONE coincides with the final sum handshake, while the FSM is still in FIN.
   assign done_fire = (state == FIN) && sum_hs && sum_last_q && !bus.ABORT;

   assign bus.OP_READY  = op_rdy;
   assign bus.SUM_VALID = sum_vld_q;
   assign bus.SUM       = sum_q;
   assign bus.SUM_LAST  = sum_last_q;
   assign bus.BUSY      = (state != IDLE);
   assign bus.DONE      = done_fire;
   assign bus.C_OUT     = c_out_q;
`ifdef BK_SEQ_OVERFLOW_EN
   assign bus.OVF       = ovf_q;
`endif

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; ABORT overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.START)          state_nxt = RUN;
         RUN:     if (accept && last_word) state_nxt = FIN;
         FIN:     if (done_fire)          state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
      if (bus.ABORT) begin
         state_nxt = IDLE;
      end
   end

   // Operation setup, inter-byte carry, word counter, output register and final flags.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode       <= 1'b0;
         carry      <= 1'b0;
         cnt        <= '0;
         sum_q      <= 8'h00;
         sum_vld_q  <= 1'b0;
         sum_last_q <= 1'b0;
         c_out_q    <= 1'b0;
`ifdef BK_SEQ_OVERFLOW_EN
         ovf_q      <= 1'b0;
`endif
      end else if (bus.ABORT) begin
         // C_OUT (and OVF) keep the last completed result.
         carry      <= 1'b0;
         cnt        <= '0;
         sum_vld_q  <= 1'b0;
         sum_last_q <= 1'b0;
      end else begin
         if (start_go) begin
            mode    <= bus.SUB;
            carry   <= bus.SUB ? 1'b1 : bus.C_IN;
            cnt     <= '0;
            c_out_q <= 1'b0;
`ifdef BK_SEQ_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
         end
         if (accept) begin
            sum_q      <= bus.ADD_S;
            sum_vld_q  <= 1'b1;
            sum_last_q <= last_word;
            carry      <= bus.ADD_COUT;
            cnt        <= cnt + CNT_W'(1);
            if (last_word) begin
               c_out_q <= bus.ADD_COUT;
`ifdef BK_SEQ_OVERFLOW_EN
               // Operand signs equal and result sign differs -> signed overflow.
               ovf_q   <= (bus.OP_A[7] == bus.ADD_B[7]) && (bus.ADD_S[7] != bus.OP_A[7]);
`endif
            end
         end else if (sum_hs) begin
            sum_vld_q  <= 1'b0;
            sum_last_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Self-checking bench for bk_multiword_add_seq with NUM_WORDS=4.
// Models the external 8-bit adder; expected sum bytes go to a scoreboard queue on operand accept.
// Build with BK_SEQ_OVERFLOW_EN defined to also check OVF.
module tb_bk_multiword_add_seq;
   localparam int NW = 4;

   typedef struct {
      logic        sub;
      logic        cin;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_sum;
      logic        exp_cout;
      logic        exp_ovf;
   } vec_t;

   logic CLK;
   logic RST_N;
   bk_multiword_add_seq_if bus ();

   bk_multiword_add_seq #(.NUM_WORDS(NW), .CNT_W(8)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   // External 8-bit adder model.
   assign {bus.ADD_COUT, bus.ADD_S} = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B} + {8'h00, bus.ADD_C0};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int         n_checks = 0;
   int         n_pass   = 0;
   int         done_cnt = 0;
   logic [8:0] exp_q[$];
   vec_t       tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Scoreboard consumer: compare every sum handshake against the queue head.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge CLK);
         if (bus.DONE === 1'b1) done_cnt++;
         if (RST_N && bus.SUM_VALID === 1'b1 && bus.SUM_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL sum_unexpected: got byte %0h with empty scoreboard, required none", bus.SUM);
            end else begin
               e = exp_q.pop_front();
               chk("sum_byte", {24'h0, bus.SUM}, {24'h0, e[7:0]});
               chk("sum_last", {31'h0, bus.SUM_LAST}, {31'h0, e[8]});
            end
         end
      end
   end

   task automatic run_op(input vec_t v, input int n_feed, input bit glitch, input string tag);
      int d0;
      int guard;
      bit acc;
      @(posedge CLK); #1;
      bus.START = 1'b1; bus.SUB = v.sub; bus.C_IN = v.cin;
      @(posedge CLK); #1;
      bus.START = glitch;
      if (glitch) begin
         bus.SUB  = !v.sub;
         bus.C_IN = !v.cin;
      end
      d0 = done_cnt;
      for (int w = 0; w < n_feed; w++) begin
         bus.OP_VALID = 1'b1;
         bus.OP_A     = v.a[8*w +: 8];
         bus.OP_B     = v.b[8*w +: 8];
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 50) begin
            @(negedge CLK);
            if (bus.OP_READY === 1'b1) begin
               acc = 1'b1;
               exp_q.push_back({(w == NW - 1), v.exp_sum[8*w +: 8]});
            end
            @(posedge CLK); #1;
            guard++;
         end
         if (!acc) begin
            n_checks++;
            $display("FAIL %s accept_timeout word %0d: OP_READY stayed low, required 1", tag, w);
         end
      end
      bus.OP_VALID = 1'b0;
      if (n_feed == NW) begin
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 50) begin
            @(negedge CLK);
            acc = (bus.DONE === 1'b1);
            guard++;
         end
         chk({tag, "_done_seen"}, {31'h0, acc}, 32'h1);
         @(posedge CLK); #1;
         bus.START = 1'b0;
         @(negedge CLK);
         chk({tag, "_busy_after"}, {31'h0, bus.BUSY}, 32'h0);
         chk({tag, "_c_out"}, {31'h0, bus.C_OUT}, {31'h0, v.exp_cout});
`ifdef BK_SEQ_OVERFLOW_EN
         chk({tag, "_ovf"}, {31'h0, bus.OVF}, {31'h0, v.exp_ovf});
`endif
         chk({tag, "_done_pulses"}, done_cnt - d0, 32'h1);
         chk({tag, "_sb_drained"}, exp_q.size(), 32'h0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_op_ready"}, {31'h0, bus.OP_READY}, 32'h0);
      chk({tag, "_sum_valid"}, {31'h0, bus.SUM_VALID}, 32'h0);
      chk({tag, "_sum"}, {24'h0, bus.SUM}, 32'h0);
      chk({tag, "_sum_last"}, {31'h0, bus.SUM_LAST}, 32'h0);
      chk({tag, "_busy"}, {31'h0, bus.BUSY}, 32'h0);
      chk({tag, "_done"}, {31'h0, bus.DONE}, 32'h0);
      chk({tag, "_c_out"}, {31'h0, bus.C_OUT}, 32'h0);
   endtask

   initial begin
      vec_t v;
      int   d0;
      int   g;
      //          sub   cin   a             b             exp_sum       cout  ovf
      tbl[0] = '{1'b0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 32'h01020304, 32'h10203040, 32'h11223344, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};

      bus.START = 0; bus.SUB = 0; bus.C_IN = 0; bus.ABORT = 0;
      bus.OP_VALID = 0; bus.OP_A = 0; bus.OP_B = 0; bus.SUM_READY = 1;
      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #2 chk_all_zero("reset");
      #9 RST_N = 1'b1;

      // Table: straight-through operations at full rate.
      for (int i = 0; i < 9; i++) begin
         run_op(tbl[i], NW, 1'b0, $sformatf("vec%0d", i));
      end

      // START (with flipped SUB/C_IN) held during RUN and FIN must be ignored.
      run_op(tbl[4], NW, 1'b1, "glitch_sub");
      run_op(tbl[0], NW, 1'b1, "glitch_add");

      // Consumer stall after the first sum byte.
      fork
         run_op(tbl[3], NW, 1'b0, "stall");
         begin
            g = 0;
            do begin
               @(posedge CLK); #1;
               g++;
            end while (bus.SUM_VALID !== 1'b1 && g < 50);
            bus.SUM_READY = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge CLK);
               chk("stall_op_ready", {31'h0, bus.OP_READY}, 32'h0);
               chk("stall_sum_valid", {31'h0, bus.SUM_VALID}, 32'h1);
               chk("stall_sum_held", {24'h0, bus.SUM}, 32'h44);
               @(posedge CLK); #1;
            end
            bus.SUM_READY = 1'b1;
         end
      join

      // ABORT after two accepted words, then a clean operation.
      v  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      d0 = done_cnt;
      run_op(v, 2, 1'b0, "abort_part");
      bus.ABORT = 1'b1;
      @(posedge CLK); #1;
      bus.ABORT = 1'b0;
      @(negedge CLK);
      chk("abort_busy", {31'h0, bus.BUSY}, 32'h0);
      chk("abort_sum_valid", {31'h0, bus.SUM_VALID}, 32'h0);
      chk("abort_sum_last", {31'h0, bus.SUM_LAST}, 32'h0);
      chk("abort_op_ready", {31'h0, bus.OP_READY}, 32'h0);
      repeat (2) @(negedge CLK);
      chk("abort_no_done", done_cnt - d0, 32'h0);
      chk("abort_sb_drained", exp_q.size(), 32'h0);
      v = '{1'b0, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0};
      run_op(v, NW, 1'b0, "after_abort");

      // Asynchronous reset in the middle of RUN.
      run_op(tbl[0], 2, 1'b0, "rst_part");
      #1 RST_N = 1'b0;
      #1 chk_all_zero("mid_reset");
      exp_q.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      run_op(tbl[1], NW, 1'b0, "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
